// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Read-side sequencer for a register file with an asynchronous read port.
// On an accepted start it latches an address range [first_addr..last_addr]
// (modulo 2**ADDR_W, so first > last wraps through 0). It then walks that
// range through the read port and streams each captured word out over a
// valid/ready handshake. The block never writes the register file.
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN):
//   When defined, every transferred register word is XOR-accumulated. After
//   the final register word, one extra checksum word is sent, and it is the
//   only word carrying out_last. When undefined, there is no checksum state
//   and out_last marks the final register word.
//
// Ports:
//   i_clk          clock, all state updates on rising edge
//   i_reset        synchronous active-high reset
//   i_start        begin a dump (only sampled while idle)
//   i_first_addr   first register to dump, latched on accepted start
//   i_last_addr    final register to dump, latched on accepted start
//   o_rd_addr      read pointer into the register file
//   i_rd_data      combinational read data for o_rd_addr
//   o_out_data     dumped word
//   o_out_valid    o_out_data is valid
//   i_out_ready    consumer accepts the word (transfer = valid && ready)
//   o_out_last     final word of the dump (meaningful while valid)
//   o_busy         high in every state except idle
//   o_done         one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // State and output registers
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  // Next-state values
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_end_addr_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_out_valid_nxt;
  logic              w_out_last_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic              w_xfer;
  logic              w_at_end;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] w_csum_nxt;

  // Fold one transferred word into the running XOR checksum.
  function automatic logic [DATA_W-1:0] f_csum_fold(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] word
  );
    return acc ^ word;
  endfunction
`endif

  assign w_xfer   = r_out_valid & i_out_ready;
  assign w_at_end = (r_addr == r_end_addr);

  // Sequencer next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_end_addr_nxt  = r_end_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_done_nxt      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr_nxt     = i_first_addr;
          w_end_addr_nxt = i_last_addr;
          w_state_nxt    = S_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_nxt     = {DATA_W{1'b0}};
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      // rd_addr already equals r_addr, so rd_data is the word to capture.
      S_FETCH: begin
        w_out_data_nxt  = i_rd_data;
        w_out_valid_nxt = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        w_out_last_nxt  = 1'b0;
`else
        w_out_last_nxt  = w_at_end;
`endif
        w_state_nxt     = S_SEND;
      end

      // Outputs hold until the consumer takes the word.
      S_SEND: begin
        if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_nxt      = f_csum_fold(r_csum, r_out_data);
`endif
          if (!w_at_end) begin
            w_addr_nxt  = r_addr + ADDR_ONE;
            w_state_nxt = S_FETCH;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
`endif
          end
        end else begin
          w_state_nxt = S_SEND;
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      // First cycle loads the finished checksum; then wait for its transfer.
      S_CSUM: begin
        if (!r_out_valid) begin
          w_out_data_nxt  = r_csum;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b1;
          w_state_nxt     = S_CSUM;
        end else if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = S_DONE;
          w_done_nxt      = 1'b1;
        end else begin
          w_state_nxt = S_CSUM;
        end
      end
`endif

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_end_addr  <= {ADDR_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum      <= {DATA_W{1'b0}};
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_end_addr  <= w_end_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  assign o_rd_addr   = r_addr;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Self-checking bench for reg_dump_reader. A behavioural register file
// answers the read port. For each dump, the expected word list is built
// from the range rules: n = ((last - first) mod 16) + 1 words at addresses
// first, first+1, ... mod 16. When REG_DUMP_CHECKSUM_EN is defined, the list
// ends with an XOR checksum word.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] rf [0:15];

  int n_checks = 0;
  int n_errors = 0;

  reg_dump_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_first_addr (first_addr),
    .i_last_addr  (last_addr),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last),
    .o_busy       (busy),
    .o_done       (done)
  );

  assign rd_data = rf[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready low 4 cycles per word, 2: random ready
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode, input bit poke);
    logic [8:0] exp_q[$];
    logic [7:0] acc;
    logic [7:0] hd;
    logic       hl;
    logic [3:0] a;
    int         n;
    int         stall_left;
    bit         active;
    bit         poked;
    bit         xfer;
    bit         finished;

    acc = 8'h00;
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    for (int i = 0; i < n; i++) begin
      a = f + 4'(i);
      acc = acc ^ rf[a];
`ifdef REG_DUMP_CHECKSUM_EN
      exp_q.push_back({1'b0, rf[a]});
`else
      exp_q.push_back({(i == n - 1), rf[a]});
`endif
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back({1'b1, acc});
`endif

    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    out_ready  = (mode == 0);
    @(posedge clk); #1;
    start      = 1'b0;
    first_addr = 4'($urandom);
    last_addr  = 4'($urandom);
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_fetch_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid", {31'd0, out_valid}, 32'd1);

    active = 1'b0;
    poked = 1'b0;
    finished = 1'b0;
    hd = 8'h00;
    hl = 1'b0;
    stall_left = 0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      start = 1'b0;
      if (out_valid) begin
        if (!active) begin
          active = 1'b1;
          hd = out_data;
          hl = out_last;
          stall_left = (mode == 1) ? 4 : 0;
        end else begin
          check("stall_data", {24'd0, out_data}, {24'd0, hd});
          check("stall_last", {31'd0, out_last}, {31'd0, hl});
        end
      end
      if (poke && active && !poked) begin
        start = 1'b1;
        first_addr = 4'd9;
        last_addr = 4'd9;
        poked = 1'b1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check("done_early", {31'd0, done}, 32'd0);
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          check("word", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
        active = 1'b0;
      end
      @(posedge clk); #1;
      if (xfer) begin
        check("gap_valid", {31'd0, out_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("done_pulse", {31'd0, done}, 32'd1);
          check("done_busy", {31'd0, busy}, 32'd1);
          start = 1'b0;
          @(posedge clk); #1;
          check("done_clear", {31'd0, done}, 32'd0);
          check("idle_busy", {31'd0, busy}, 32'd0);
          check("idle_valid", {31'd0, out_valid}, 32'd0);
          finished = 1'b1;
        end
      end
    end
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    first_addr = 4'd0;
    last_addr = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'(i * 16 + i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic dump 0..3
    rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
    run_dump(4'd0, 4'd3, 0, 1'b0);

    // Wrap-around 14..1
    rf[14] = 8'hAA; rf[15] = 8'hBB; rf[0] = 8'hCC; rf[1] = 8'hDD;
    run_dump(4'd14, 4'd1, 0, 1'b0);

    // Single word
    rf[5] = 8'h5A;
    run_dump(4'd5, 4'd5, 0, 1'b0);

    // Stalled dump 0..2
    run_dump(4'd0, 4'd2, 1, 1'b0);

    // Start re-asserted mid-dump must be ignored
    run_dump(4'd2, 4'd6, 0, 1'b1);

    // Full range
    run_dump(4'd0, 4'd15, 2, 1'b0);

    // Reset during SEND of the second word
    start = 1'b1; first_addr = 4'd0; last_addr = 4'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_w1_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_w2_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_data", {24'd0, out_data}, 32'd0);
    check("rst_mid_rd_addr", {28'd0, rd_addr}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_no_done", {31'd0, done}, 32'd0);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);
    rf[6] = 8'h66; rf[7] = 8'h77; rf[8] = 8'h88;
    run_dump(4'd6, 4'd8, 0, 1'b0);

    // Randomised dumps
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
      run_dump(4'($urandom), 4'($urandom), (t % 3 == 0) ? 1 : 2, (t % 4 == 1));
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
